// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle for the load/store data memory.
// The master drives requests; the slave returns responses and status.
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_error;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_address, req_wdata,
    input  req_ready, resp_valid, resp_data,
    input  resp_error, busy
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_address, req_wdata,
    output req_ready, resp_valid, resp_data,
    output resp_error, busy
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with sized, masked accesses,
// error flagging, optional clear after reset and a fixed-latency response pipe.
module data_memory_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 128,
  parameter int ADDR_WIDTH     = 64,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  data_memory_ctrl_if.slave bus
);
  localparam int B  = DATA_WIDTH / 8;
  localparam int LB = $clog2(B);
  localparam int LD = $clog2(DEPTH);
  localparam int IW = LB + LD;

  typedef enum logic {INIT, RUN} state_t;

  state_t state_q, state_d;
  logic [LD-1:0] clr_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc;
  logic                  misal;
  logic                  oversz;
  logic                  oor;
  logic                  err;
  logic [LD-1:0]         idx;
  logic [LB-1:0]         lane;
  logic [3:0]            nbytes;
  logic [2:0]            szmask;
  logic [6:0]            nbits;
  logic                  full;
  int                    msb_i;
  logic [DATA_WIDTH-1:0] fmask;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic [DATA_WIDTH-1:0] wd_sh;
  logic [B-1:0]          be;

  logic                  pv [READ_LATENCY];
  logic                  pe [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? INIT : RUN;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    if (rst) begin
      bus.busy = CLEAR_ON_RESET;
    end else begin
      unique case (state_q)
        INIT: begin
          bus.busy = 1'b1;
          if (clr_cnt == LD'(DEPTH - 1)) state_d = RUN;
        end
        RUN: bus.req_ready = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  assign acc    = bus.req_valid && bus.req_ready;
  assign idx    = bus.req_address[IW-1:LB];
  assign lane   = bus.req_address[LB-1:0];
  assign nbytes = 4'd1 << bus.req_size;
  assign szmask = 3'(nbytes - 4'd1);
  assign misal  = |(bus.req_address[2:0] & szmask);
  assign oversz = nbytes > 4'(B);
  assign oor    = (bus.req_address >> IW) != '0;
  assign err    = misal || oversz || oor;

  // Read data: shift the lane to the LSBs, then mask and extend.
  always_comb begin
    nbits    = 7'(nbytes) << 3;
    full     = int'(nbits) >= DATA_WIDTH;
    msb_i    = full ? DATA_WIDTH - 1 : int'(nbits) - 1;
    fmask    = full ? '1 : ~({DATA_WIDTH{1'b1}} << nbits);
    rd_shift = mem[idx] >> {lane, 3'b000};
    rd_ext   = rd_shift & fmask;
    if (!full && !bus.req_unsigned && rd_shift[msb_i])
      rd_ext = rd_ext | ~fmask;
  end

  always_comb begin
    wd_sh = bus.req_wdata << {lane, 3'b000};
    be    = '0;
    for (int i = 0; i < B; i++)
      be[i] = (i >= int'(lane)) &&
              (i < int'(lane) + int'(nbytes));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem[clr_cnt] <= '0;
      end else if (acc && bus.req_write && !err) begin
        for (int i = 0; i < B; i++)
          if (be[i]) mem[idx][8*i +: 8] <= wd_sh[8*i +: 8];
      end
    end
  end

  // Data/error stages only load on a valid entry so the output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= 1'b0;
        pd[k] <= '0;
      end
    end else begin
      pv[0] <= acc;
      if (acc) begin
        pe[0] <= err;
        pd[0] <= (bus.req_write || err) ? '0 : rd_ext;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          pe[k] <= pe[k-1];
          pd[k] <= pd[k-1];
        end
      end
    end
  end

  assign bus.resp_valid = pv[READ_LATENCY-1] && !rst;
  assign bus.resp_error = pe[READ_LATENCY-1] && !rst;
  assign bus.resp_data  = rst ? '0 : pd[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl over three configurations:
// default, 3-cycle latency with short clear, and 32-bit without clear.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   bc;
  int   seen;
  logic        rv;
  logic        re;
  logic [63:0] rd;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) m0 ();
  data_memory_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) m1 ();
  data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m2 ();

  data_memory_ctrl u0 (.clk(clk), .rst(rst0), .bus(m0));

  data_memory_ctrl #(
    .DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(64),
    .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)
  ) u1 (.clk(clk), .rst(rst1), .bus(m1));

  data_memory_ctrl #(
    .DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(32),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
  ) u2 (.clk(clk), .rst(rst2), .bus(m2));

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc0(input logic w, input logic [1:0] sz,
                      input logic u, input logic [63:0] a,
                      input logic [63:0] wd);
    @(negedge clk);
    m0.req_valid = 1'b1; m0.req_write = w; m0.req_size = sz;
    m0.req_unsigned = u; m0.req_address = a; m0.req_wdata = wd;
    @(negedge clk);
    m0.req_valid = 1'b0;
    rv = m0.resp_valid; rd = m0.resp_data; re = m0.resp_error;
  endtask

  task automatic acc2(input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] wd);
    @(negedge clk);
    m2.req_valid = 1'b1; m2.req_write = w; m2.req_size = sz;
    m2.req_unsigned = u; m2.req_address = a; m2.req_wdata = wd;
    @(negedge clk);
    m2.req_valid = 1'b0;
    rv = m2.resp_valid; rd = 64'(m2.resp_data); re = m2.resp_error;
  endtask

  task automatic drv1(input logic v, input logic w,
                      input logic [63:0] a, input logic [63:0] wd);
    m1.req_valid = v; m1.req_write = w; m1.req_size = 2'd3;
    m1.req_unsigned = 1'b0; m1.req_address = a; m1.req_wdata = wd;
  endtask

  initial begin
    m0.req_valid = 0; m0.req_write = 0; m0.req_size = 0;
    m0.req_unsigned = 0; m0.req_address = 0; m0.req_wdata = 0;
    m2.req_valid = 0; m2.req_write = 0; m2.req_size = 0;
    m2.req_unsigned = 0; m2.req_address = 0; m2.req_wdata = 0;
    drv1(1'b0, 1'b0, 64'h0, 64'h0);

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(m0.req_ready), 64'd0);
    chk("rst_busy", 64'(m0.busy), 64'd1);
    chk("rst_rvalid", 64'(m0.resp_valid), 64'd0);
    chk("rst_rdata", m0.resp_data, 64'd0);
    chk("rst_rerr", 64'(m0.resp_error), 64'd0);

    rst0 = 1'b0;
    #1;
    bc = 0;
    while (m0.busy && bc < 1000) begin
      chk("clr_ready", 64'(m0.req_ready), 64'd0);
      bc++;
      @(negedge clk);
    end
    chk("clr_cycles", 64'(bc), 64'd128);
    chk("run_ready", 64'(m0.req_ready), 64'd1);

    acc0(1'b0, 2'd3, 1'b0, 64'h0, 64'h0);
    chk("ld0_valid", 64'(rv), 64'd1);
    chk("ld0_data", rd, 64'h0);

    acc0(1'b1, 2'd3, 1'b0, 64'h8, 64'h1122334455667788);
    chk("st8_valid", 64'(rv), 64'd1);
    chk("st8_data", rd, 64'h0);
    chk("st8_err", 64'(re), 64'd0);
    acc0(1'b0, 2'd0, 1'b1, 64'hF, 64'h0);
    chk("ldb_f", rd, 64'h11);
    acc0(1'b0, 2'd1, 1'b0, 64'hC, 64'h0);
    chk("ldh_c", rd, 64'h3344);
    acc0(1'b0, 2'd2, 1'b0, 64'h8, 64'h0);
    chk("ldw_8", rd, 64'h55667788);
    acc0(1'b0, 2'd2, 1'b0, 64'hC, 64'h0);
    chk("ldw_c", rd, 64'h11223344);

    @(negedge clk);
    chk("hold_valid", 64'(m0.resp_valid), 64'd0);
    chk("hold_data", m0.resp_data, 64'h11223344);

    acc0(1'b1, 2'd0, 1'b0, 64'h10, 64'hAB80);
    acc0(1'b0, 2'd0, 1'b0, 64'h10, 64'h0);
    chk("ldb_s", rd, 64'hFFFFFFFFFFFFFF80);
    acc0(1'b0, 2'd0, 1'b1, 64'h10, 64'h0);
    chk("ldb_u", rd, 64'h80);
    acc0(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
    chk("ldd_10", rd, 64'h80);

    acc0(1'b1, 2'd2, 1'b0, 64'h18, 64'hFFFFFFFF80000001);
    acc0(1'b0, 2'd2, 1'b0, 64'h18, 64'h0);
    chk("ldw_s", rd, 64'hFFFFFFFF80000001);
    acc0(1'b0, 2'd3, 1'b1, 64'h18, 64'h0);
    chk("ldd_18", rd, 64'h0000000080000001);

    acc0(1'b1, 2'd1, 1'b0, 64'h11, 64'hFFFF);
    chk("mis_err", 64'(re), 64'd1);
    chk("mis_data", rd, 64'h0);
    acc0(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
    chk("mis_kept", rd, 64'h80);
    chk("mis_kept_err", 64'(re), 64'd0);
    acc0(1'b0, 2'd0, 1'b0, 64'h400, 64'h0);
    chk("oor_err", 64'(re), 64'd1);
    chk("oor_data", rd, 64'h0);

    @(negedge clk);
    rst1 = 1'b0;
    #1;
    bc = 0;
    while (m1.busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    chk("u1_clr", 64'(bc), 64'd16);

    drv1(1'b1, 1'b1, 64'h20, 64'hDEAD);
    @(negedge clk);
    chk("p_k1", 64'(m1.resp_valid), 64'd0);
    drv1(1'b1, 1'b0, 64'h20, 64'h0);
    @(negedge clk);
    chk("p_k2", 64'(m1.resp_valid), 64'd0);
    drv1(1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk("p_st_valid", 64'(m1.resp_valid), 64'd1);
    chk("p_st_data", m1.resp_data, 64'h0);
    @(negedge clk);
    chk("p_ld_valid", 64'(m1.resp_valid), 64'd1);
    chk("p_ld_data", m1.resp_data, 64'hDEAD);
    @(negedge clk);
    chk("p_k5", 64'(m1.resp_valid), 64'd0);
    chk("p_k5_hold", m1.resp_data, 64'hDEAD);

    drv1(1'b1, 1'b0, 64'h20, 64'h0);
    @(negedge clk);
    @(negedge clk);
    drv1(1'b0, 1'b0, 64'h0, 64'h0);
    rst1 = 1'b1;
    #1;
    chk("fl_rvalid", 64'(m1.resp_valid), 64'd0);
    chk("fl_busy", 64'(m1.busy), 64'd1);
    @(negedge clk);
    rst1 = 1'b0;
    seen = 0;
    bc = 0;
    repeat (5) begin
      @(negedge clk);
      if (m1.resp_valid) seen++;
      if (m1.busy) bc++;
    end
    chk("fl_stale", 64'(seen), 64'd0);
    chk("fl_busy_n", 64'(bc), 64'd5);

    chk("u2_rst_busy", 64'(m2.busy), 64'd0);
    chk("u2_rst_ready", 64'(m2.req_ready), 64'd0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("u2_ready", 64'(m2.req_ready), 64'd1);
    chk("u2_busy", 64'(m2.busy), 64'd0);
    acc2(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    chk("u2_ovs_err", 64'(re), 64'd1);
    chk("u2_ovs_data", rd, 64'h0);
    acc2(1'b1, 2'd2, 1'b0, 32'h4, 32'h89ABCDEF);
    chk("u2_st_err", 64'(re), 64'd0);
    acc2(1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
    chk("u2_ldh_s", rd, 64'hFFFF89AB);
    acc2(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    chk("u2_ldb_u", rd, 64'hCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
